// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Moore control sequencer for a multicycle MIPS datapath.
//                Steps each instruction through fetch/decode/execute/memory/
//                writeback, drives mux selects and write strobes, and
//                stretches memory cycles with the MemReady handshake.
//                Optional macro MC_CTRL_PERF_EN adds cycle and retired-
//                instruction counters (CycleCount, InstrCount).
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm (
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  Opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSrc,
    output logic        PCEn,
    output logic        IllegalOp
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] CycleCount,
    output logic [31:0] InstrCount
`endif
);

    // State encoding (4-bit binary)
    localparam logic [3:0] c_ST_FETCH   = 4'd0;
    localparam logic [3:0] c_ST_DECODE  = 4'd1;
    localparam logic [3:0] c_ST_MEMADR  = 4'd2;
    localparam logic [3:0] c_ST_MEMRD   = 4'd3;
    localparam logic [3:0] c_ST_MEMWB   = 4'd4;
    localparam logic [3:0] c_ST_MEMWR   = 4'd5;
    localparam logic [3:0] c_ST_EXECUTE = 4'd6;
    localparam logic [3:0] c_ST_ALUWB   = 4'd7;
    localparam logic [3:0] c_ST_ADDIEX  = 4'd8;
    localparam logic [3:0] c_ST_ADDIWB  = 4'd9;
    localparam logic [3:0] c_ST_BRANCH  = 4'd10;
    localparam logic [3:0] c_ST_JUMP    = 4'd11;

    // Supported opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    logic [3:0] r_state;
    logic [3:0] w_next_state;

    // Raw (ungated) strobes and internal PC controls
    logic       w_iord;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regdst;
    logic       w_memtoreg;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [1:0] w_pcsrc;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_illegal;

    // State register; the only storage in the sequencer proper
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Per-state output decode and next-state selection
    always_comb begin
        w_iord       = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_regdst     = 1'b0;
        w_memtoreg   = 1'b0;
        w_regwrite   = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_aluop      = 2'b00;
        w_pcsrc      = 2'b00;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_illegal    = 1'b0;
        w_next_state = c_ST_FETCH;

        case (r_state)
            c_ST_FETCH: begin
                // PC+4 through the ALU; IR and PC load when memory delivers
                w_alusrcb    = 2'b01;
                w_irwrite    = MemReady;
                w_pc_write   = MemReady;
                w_next_state = MemReady ? c_ST_DECODE : c_ST_FETCH;
            end
            c_ST_DECODE: begin
                // Precompute branch target while the opcode is decoded
                w_alusrcb = 2'b11;
                case (Opcode)
                    c_OP_LW,
                    c_OP_SW:    w_next_state = c_ST_MEMADR;
                    c_OP_RTYPE: w_next_state = c_ST_EXECUTE;
                    c_OP_ADDI:  w_next_state = c_ST_ADDIEX;
                    c_OP_BEQ:   w_next_state = c_ST_BRANCH;
                    c_OP_J:     w_next_state = c_ST_JUMP;
                    default: begin
                        w_illegal    = 1'b1;
                        w_next_state = c_ST_FETCH;
                    end
                endcase
            end
            c_ST_MEMADR: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_next_state = (Opcode == c_OP_SW) ? c_ST_MEMWR : c_ST_MEMRD;
            end
            c_ST_MEMRD: begin
                w_iord       = 1'b1;
                w_next_state = MemReady ? c_ST_MEMWB : c_ST_MEMRD;
            end
            c_ST_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
            end
            c_ST_MEMWR: begin
                // Write strobe is held for every wait cycle
                w_iord       = 1'b1;
                w_memwrite   = 1'b1;
                w_next_state = MemReady ? c_ST_FETCH : c_ST_MEMWR;
            end
            c_ST_EXECUTE: begin
                w_alusrca    = 1'b1;
                w_aluop      = 2'b10;
                w_next_state = c_ST_ALUWB;
            end
            c_ST_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            c_ST_ADDIEX: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_next_state = c_ST_ADDIWB;
            end
            c_ST_ADDIWB: begin
                w_regwrite = 1'b1;
            end
            c_ST_BRANCH: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b01;
                w_pcsrc   = 2'b01;
                w_branch  = 1'b1;
            end
            c_ST_JUMP: begin
                w_pcsrc    = 2'b10;
                w_pc_write = 1'b1;
            end
            default: begin
                // Unused encodings fall back to FETCH with everything idle
                w_next_state = c_ST_FETCH;
            end
        endcase
    end

    // Selects come straight from state (reset already forces FETCH);
    // strobes are additionally masked while reset is held.
    assign IorD      = w_iord;
    assign RegDst    = w_regdst;
    assign MemtoReg  = w_memtoreg;
    assign ALUSrcA   = w_alusrca;
    assign ALUSrcB   = w_alusrcb;
    assign ALUOp     = w_aluop;
    assign PCSrc     = w_pcsrc;
    assign MemWrite  = w_memwrite & ~RST;
    assign IRWrite   = w_irwrite  & ~RST;
    assign RegWrite  = w_regwrite & ~RST;
    assign IllegalOp = w_illegal  & ~RST;
    assign PCEn      = (w_pc_write | (w_branch & Zero)) & ~RST;

`ifdef MC_CTRL_PERF_EN
    logic        w_retire;
    logic [31:0] r_cycle_count;
    logic [31:0] r_instr_count;

    // An instruction retires on any transition back to FETCH except the
    // illegal-opcode path out of DECODE.
    assign w_retire = (r_state == c_ST_MEMWB)  ||
                      (r_state == c_ST_ALUWB)  ||
                      (r_state == c_ST_ADDIWB) ||
                      (r_state == c_ST_BRANCH) ||
                      (r_state == c_ST_JUMP)   ||
                      ((r_state == c_ST_MEMWR) && MemReady);

    // Free-running cycle and retired-instruction counters, wrapping at 2^32
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cycle_count <= 32'd0;
            r_instr_count <= 32'd0;
        end else begin
            r_cycle_count <= r_cycle_count + 32'd1;
            if (w_retire) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
        end
    end

    assign CycleCount = r_cycle_count;
    assign InstrCount = r_instr_count;
`endif

endmodule
`default_nettype wire
